// File: rtl/instr_fetch_issue_pkg.sv
// Shared constants for the instruction memory, fetch/issue stage and cache controller.
// Holds field layout, opcodes and FSM state encoding.
package instr_fetch_issue_pkg;

  localparam int PC_W     = 5;
  localparam int INSTR_W  = 10;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 4;
  localparam int RET_W    = 8;
  localparam int LAST_PC  = 31;
  localparam int MAX_WAIT = 15;
  localparam int WAIT_W   = 4;

  localparam int OP_MSB   = 9;
  localparam int OP_LSB   = 8;
  localparam int ADDR_MSB = 7;
  localparam int ADDR_LSB = 4;
  localparam int DATA_MSB = 3;
  localparam int DATA_LSB = 0;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_WAIT,
    S_HALTED
  } state_t;

endpackage

// File: rtl/instr_fetch_issue.sv
// Fetch/issue stage: walks the instruction memory, turns each word into one
// cache request and holds it until the cache controller acknowledges.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | out of reset, pc = 0, waiting for start
// S_FETCH  | mem_pc presented, memory registers the word at the closing edge
// S_DECODE | instruction captured; NOP retires, HALT stops, READ/WRITE issue
// S_WAIT   | request held until req_done or the wait budget runs out
// S_HALTED | program finished (HALT, last address retired or timeout)
module instr_fetch_issue
  import instr_fetch_issue_pkg::*;
(
  input  logic               clock,
  input  logic               clear_n,
  input  logic               start,
  output logic [PC_W-1:0]    mem_pc,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               req_valid,
  output logic               req_we,
  output logic [ADDR_W-1:0]  req_addr,
  output logic [DATA_W-1:0]  req_data,
  input  logic               req_done,
  input  logic [DATA_W-1:0]  rd_data,
  output logic [DATA_W-1:0]  last_rd,
  output logic [RET_W-1:0]   retired,
  output logic               busy,
  output logic               halted,
  output logic               error
);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   last_rd_q, last_rd_d;
  logic [RET_W-1:0]    retired_q, retired_d;
  logic                error_q, error_d;
  logic                retire;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      wait_q    <= '0;
      valid_q   <= 1'b0;
      last_rd_q <= '0;
      retired_q <= '0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      valid_q   <= valid_d;
      last_rd_q <= last_rd_d;
      retired_q <= retired_d;
      error_q   <= error_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    valid_d   = valid_q;
    last_rd_d = last_rd_q;
    retired_d = retired_q;
    error_d   = error_q;
    retire    = 1'b0;

    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = '0;
          error_d   = 1'b0;
          retired_d = '0;
          last_rd_d = '0;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        ir_d = instr_in;
        case (instr_in[OP_MSB:OP_LSB])
          OP_NOP:  retire = 1'b1;
          OP_HALT: state_d = S_HALTED;
          default: begin
            valid_d = 1'b1;
            wait_d  = '0;
            state_d = S_WAIT;
          end
        endcase
      end
      S_WAIT: begin
        if (req_done) begin
          valid_d = 1'b0;
          retire  = 1'b1;
          if (ir_q[OP_MSB:OP_LSB] == OP_READ) last_rd_d = rd_data;
        end else begin
          wait_d = wait_q + 1'b1;
          // Timeout on the edge where the count reaches MAX_WAIT, i.e. after MAX_WAIT WAIT cycles.
          if (wait_q == WAIT_W'(MAX_WAIT - 1)) begin
            error_d = 1'b1;
            valid_d = 1'b0;
            state_d = S_HALTED;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (retire) begin
      retired_d = retired_q + 1'b1;
      if (pc_q == PC_W'(LAST_PC)) begin
        state_d = S_HALTED;
      end else begin
        pc_d    = pc_q + 1'b1;
        state_d = S_FETCH;
      end
    end
  end

  // Request fields come straight from the captured word, so they stay stable through WAIT.
  assign mem_pc    = pc_q;
  assign req_valid = valid_q;
  assign req_we    = (ir_q[OP_MSB:OP_LSB] == OP_WRITE);
  assign req_addr  = ir_q[ADDR_MSB:ADDR_LSB];
  assign req_data  = req_we ? ir_q[DATA_MSB:DATA_LSB] : '0;
  assign last_rd   = last_rd_q;
  assign retired   = retired_q;
  assign error     = error_q;
  assign halted    = (state_q == S_HALTED);
  assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_WAIT);

endmodule
